// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port ROM arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package rom_arb_pkg;

  localparam int ADR_WIDTH_DEF  = 13;
  localparam int DATA_WIDTH_DEF = 32;

  // Who owns the ROM slot (or the response coming back from it).
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  // Round-robin pick: I wins when it is the only requester, or on a
  // conflict when D was the last port to use the ROM.
  function automatic logic i_wins(input logic i_req, input logic d_req,
                                  input owner_t last_owner);
    return i_req & (~d_req | (last_owner != OWN_I));
  endfunction

endpackage

// File: rtl/rom_arb_lastbuf.sv
// One last-word buffer: remembers the most recent ROM word returned to a port.
// Latency: hit is combinational on req_adr; fill takes effect at the next edge.
// Backpressure: none; fill_vld is accepted unconditionally.
module rom_arb_lastbuf
  import rom_arb_pkg::*;
#(
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_vld,
  input  logic [ADR_WIDTH-1:0]  fill_adr,
  input  logic [DATA_WIDTH-1:0] fill_dat,
  input  logic [ADR_WIDTH-1:0]  req_adr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] buf_dat
);

  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  vld_q, vld_d;

  // Capture the returning word; the ROM is read-only so entries never go stale.
  always_comb begin
    adr_d = adr_q;
    dat_d = dat_q;
    vld_d = vld_q;
    if (fill_vld) begin
      adr_d = fill_adr;
      dat_d = fill_dat;
      vld_d = 1'b1;
    end
  end

  // Buffer registers; only the valid bit needs a reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      adr_q <= adr_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign hit     = vld_q & (adr_q == req_adr);
  assign buf_dat = dat_q;

endmodule

// File: rtl/rom_arbiter.sv
// Shares a 1-cycle single-port ROM between the I (fetch) and D (load) ports, round-robin.
// Latency: GNT/ROM_EN/ROM_A combinational; RVALID/RDATA exactly one cycle after GNT.
// Backpressure: none on responses; REQ waits for GNT. Option: ROM_ARB_LASTHIT_EN.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_REQ,
  input  logic [ADR_WIDTH-1:0]  I_ADDR,
  output logic                  I_GNT,
  output logic                  I_RVALID,
  output logic [DATA_WIDTH-1:0] I_RDATA,
  input  logic                  D_REQ,
  input  logic [ADR_WIDTH-1:0]  D_ADDR,
  output logic                  D_GNT,
  output logic                  D_RVALID,
  output logic [DATA_WIDTH-1:0] D_RDATA,
  output logic                  ROM_EN,
  output logic [ADR_WIDTH-1:0]  ROM_A,
  input  logic [DATA_WIDTH-1:0] ROM_DO
);

  owner_t                last_owner_q, last_owner_d;
  owner_t                resp_owner_q, resp_owner_d;
  logic [ADR_WIDTH-1:0]  rom_a_q, rom_a_d;

  logic                  i_hit, d_hit;
  logic                  i_hit_q, d_hit_q;
  logic [DATA_WIDTH-1:0] i_hit_dat_q, d_hit_dat_q;
  logic                  i_rom_req, d_rom_req;
  logic                  i_rom_gnt, d_rom_gnt;
  logic                  i_rom_rsp, d_rom_rsp;

  // A ROM response is in flight for whichever port owned the slot last cycle.
  assign i_rom_rsp = (resp_owner_q == OWN_I) & ~RST;
  assign d_rom_rsp = (resp_owner_q == OWN_D) & ~RST;

`ifdef ROM_ARB_LASTHIT_EN
  logic                  i_buf_hit, d_buf_hit;
  logic [DATA_WIDTH-1:0] i_buf_dat, d_buf_dat;
  logic                  i_hit_d, d_hit_d;
  logic [DATA_WIDTH-1:0] i_hit_dat_d, d_hit_dat_d;

  // rom_a_q still holds the address whose word is returning this cycle.
  rom_arb_lastbuf #(.ADR_WIDTH(ADR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_i_buf (
    .clk(CLK), .rst(RST), .fill_vld(i_rom_rsp), .fill_adr(rom_a_q),
    .fill_dat(ROM_DO), .req_adr(I_ADDR), .hit(i_buf_hit), .buf_dat(i_buf_dat)
  );
  rom_arb_lastbuf #(.ADR_WIDTH(ADR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_d_buf (
    .clk(CLK), .rst(RST), .fill_vld(d_rom_rsp), .fill_adr(rom_a_q),
    .fill_dat(ROM_DO), .req_adr(D_ADDR), .hit(d_buf_hit), .buf_dat(d_buf_dat)
  );

  assign i_hit = I_REQ & i_buf_hit & ~RST;
  assign d_hit = D_REQ & d_buf_hit & ~RST;

  // Snapshot hit data now: a fill landing this same edge must not alter it.
  always_comb begin
    i_hit_d     = i_hit;
    d_hit_d     = d_hit;
    i_hit_dat_d = i_buf_dat;
    d_hit_dat_d = d_buf_dat;
  end

  // Hit response registers, one cycle behind the hit grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_hit_q     <= 1'b0;
      d_hit_q     <= 1'b0;
      i_hit_dat_q <= '0;
      d_hit_dat_q <= '0;
    end else begin
      i_hit_q     <= i_hit_d;
      d_hit_q     <= d_hit_d;
      i_hit_dat_q <= i_hit_dat_d;
      d_hit_dat_q <= d_hit_dat_d;
    end
  end
`else
  assign i_hit       = 1'b0;
  assign d_hit       = 1'b0;
  assign i_hit_q     = 1'b0;
  assign d_hit_q     = 1'b0;
  assign i_hit_dat_q = '0;
  assign d_hit_dat_q = '0;
`endif

  // ROM slot arbitration and next state of owner/address registers.
  always_comb begin
    i_rom_req    = I_REQ & ~i_hit & ~RST;
    d_rom_req    = D_REQ & ~d_hit & ~RST;
    i_rom_gnt    = i_wins(i_rom_req, d_rom_req, last_owner_q);
    d_rom_gnt    = d_rom_req & ~i_rom_gnt;
    rom_a_d      = rom_a_q;
    last_owner_d = last_owner_q;
    resp_owner_d = OWN_NONE;
    if (i_rom_gnt) begin
      rom_a_d      = I_ADDR;
      last_owner_d = OWN_I;
      resp_owner_d = OWN_I;
    end else if (d_rom_gnt) begin
      rom_a_d      = D_ADDR;
      last_owner_d = OWN_D;
      resp_owner_d = OWN_D;
    end
  end

  // Arbiter state; last_owner resets to D so I wins the first conflict.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_owner_q <= OWN_D;
      resp_owner_q <= OWN_NONE;
      rom_a_q      <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      resp_owner_q <= resp_owner_d;
      rom_a_q      <= rom_a_d;
    end
  end

  assign I_GNT  = i_hit | i_rom_gnt;
  assign D_GNT  = d_hit | d_rom_gnt;
  assign ROM_EN = i_rom_gnt | d_rom_gnt;
  assign ROM_A  = rom_a_d;

  // RST squashes any in-flight response in the same cycle.
  assign I_RVALID = (i_rom_rsp | i_hit_q) & ~RST;
  assign D_RVALID = (d_rom_rsp | d_hit_q) & ~RST;
  assign I_RDATA  = ~I_RVALID ? '0 : (i_hit_q ? i_hit_dat_q : ROM_DO);
  assign D_RDATA  = ~D_RVALID ? '0 : (d_hit_q ? d_hit_dat_q : ROM_DO);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios followed by random traffic.
// Latency: checks each cycle on the falling edge against a queue-based model.
// Backpressure: none; responses are consumed as they arrive.
module tb_rom_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
`ifdef ROM_ARB_LASTHIT_EN
  localparam bit LASTHIT = 1'b1;
`else
  localparam bit LASTHIT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST, I_REQ, D_REQ;
  logic [AW-1:0] I_ADDR, D_ADDR, ROM_A;
  logic          I_GNT, I_RVALID, D_GNT, D_RVALID, ROM_EN;
  logic [DW-1:0] I_RDATA, D_RDATA, ROM_DO;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];

  rom_arbiter dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .ROM_EN(ROM_EN), .ROM_A(ROM_A), .ROM_DO(ROM_DO)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port ROM with one cycle of read latency.
  always @(posedge CLK) begin
    if (ROM_EN) ROM_DO <= rom_mem[ROM_A];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: each port has a queue of expected responses tagged with the
  // cycle they are due; plus the round-robin memory and per-port last-word buffers.
  typedef struct {
    int          due;
    logic [31:0] dat;
    logic [12:0] adr;
    bit          rom;
  } resp_t;

  resp_t       iq[$];
  resp_t       dq[$];
  bit          last_was_i = 1'b0;
  bit          ib_v = 1'b0, db_v = 1'b0;
  logic [12:0] ib_a = '0,   db_a = '0;
  logic [31:0] ib_d = '0,   db_d = '0;

  task automatic cycle(input bit rst, input bit ireq, input logic [12:0] ia,
                       input bit dreq, input logic [12:0] da);
    bit          ih, dh, ir, dr, iw, dw, e_iv, e_dv;
    logic [31:0] e_id, e_dd;
    resp_t       r;
    RST = rst; I_REQ = ireq; I_ADDR = ia; D_REQ = dreq; D_ADDR = da;
    @(negedge CLK);
    e_iv = !rst && iq.size() > 0 && iq[0].due == cyc;
    e_dv = !rst && dq.size() > 0 && dq[0].due == cyc;
    e_id = e_iv ? iq[0].dat : 32'h0;
    e_dd = e_dv ? dq[0].dat : 32'h0;
    ih = !rst && LASTHIT && ireq && ib_v && ib_a == ia;
    dh = !rst && LASTHIT && dreq && db_v && db_a == da;
    ir = !rst && ireq && !ih;
    dr = !rst && dreq && !dh;
    iw = ir && (!dr || !last_was_i);
    dw = dr && !iw;
    chk_eq("i_gnt", I_GNT, ih || iw);
    chk_eq("d_gnt", D_GNT, dh || dw);
    chk_eq("rom_en", ROM_EN, iw || dw);
    if (iw) chk_eq("rom_a_i", ROM_A, ia);
    if (dw) chk_eq("rom_a_d", ROM_A, da);
    chk_eq("i_rvalid", I_RVALID, e_iv);
    chk_eq("i_rdata", I_RDATA, e_id);
    chk_eq("d_rvalid", D_RVALID, e_dv);
    chk_eq("d_rdata", D_RDATA, e_dd);
    if (rst) begin
      iq.delete(); dq.delete();
      last_was_i = 1'b0; ib_v = 1'b0; db_v = 1'b0;
    end else begin
      // New requests first: hits see the buffer contents before this cycle's fill.
      if (ih) begin r.due = cyc + 1; r.dat = ib_d; r.adr = ia; r.rom = 1'b0; iq.push_back(r); end
      if (dh) begin r.due = cyc + 1; r.dat = db_d; r.adr = da; r.rom = 1'b0; dq.push_back(r); end
      if (iw) begin r.due = cyc + 1; r.dat = rom_mem[ia]; r.adr = ia; r.rom = 1'b1; iq.push_back(r); last_was_i = 1'b1; end
      if (dw) begin r.due = cyc + 1; r.dat = rom_mem[da]; r.adr = da; r.rom = 1'b1; dq.push_back(r); last_was_i = 1'b0; end
      if (e_iv) begin r = iq.pop_front(); if (r.rom) begin ib_v = 1'b1; ib_a = r.adr; ib_d = r.dat; end end
      if (e_dv) begin r = dq.pop_front(); if (r.rom) begin db_v = 1'b1; db_a = r.adr; db_d = r.dat; end end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    RST = 1'b1; I_REQ = 1'b0; D_REQ = 1'b0; I_ADDR = '0; D_ADDR = '0;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;
    rom_mem[4] = 32'hDEADBEEF;
    @(posedge CLK);
    #1;

    // Reset held with both ports requesting, then first conflict goes to I.
    for (int i = 0; i < 3; i++) cycle(1, 1, 13'h0010, 1, 13'h0020);
    cycle(0, 1, 13'h0010, 1, 13'h0020);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // Single I read of word 4.
    cycle(0, 1, 13'h0004, 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // Sustained conflict alternates between the ports.
    cycle(1, 0, 13'h0, 0, 13'h0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 13'h0010, 1, 13'h0020);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // I streams eight consecutive words without bubbles.
    for (int i = 0; i < 8; i++) cycle(0, 1, 13'(i), 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // Reset right after a D grant discards the response.
    cycle(0, 0, 13'h0, 1, 13'h0033);
    cycle(1, 0, 13'h0, 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // Repeat read of 0x40 alongside a D read of 0x50 (hits when buffers exist).
    cycle(0, 1, 13'h0040, 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);
    cycle(0, 1, 13'h0040, 1, 13'h0050);
    cycle(0, 0, 13'h0, 0, 13'h0);

    // Random traffic over a small address range so buffers hit often.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 13'($urandom_range(0, 11)),
            $urandom_range(0, 2) != 0, 13'($urandom_range(0, 11)));
    end
    cycle(0, 0, 13'h0, 0, 13'h0);
    cycle(0, 0, 13'h0, 0, 13'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
